// File: rtl/axi4_uart_ctrl_if.sv
// AXI4 slave bus bundle for the UART transmitter register window.
interface axi4_uart_ctrl_if;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_awaddr;
  logic        s_wvalid;
  logic        s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid;
  logic        s_bready;
  logic [1:0]  s_bresp;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_araddr;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    input  s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp,
    output s_arready, s_rvalid, s_rdata, s_rresp
  );

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    output s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp,
    input  s_arready, s_rvalid, s_rdata, s_rresp
  );
endinterface

// File: rtl/axi4_uart_ctrl.sv
// AXI4 slave UART transmitter: TXDATA/STATUS/DIV registers, TX FIFO with
// bus backpressure, and an 8N1 serialiser with a run-time baud divisor.
module axi4_uart_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
  parameter int          FIFO_DEPTH = 16,
  parameter int          BAUD_DIV   = 104
) (
  input  logic            clk,
  input  logic            rst_n,
  axi4_uart_ctrl_if.slave s,
  output logic            uart_tx,
  output logic            uart_active
);
  localparam int            AW          = $clog2(FIFO_DEPTH);
  localparam int            LW          = AW + 1;
  localparam logic [LW-1:0] DEPTH_L     = LW'(FIFO_DEPTH);
  localparam logic [1:0]    REG_TXDATA  = 2'd0;
  localparam logic [1:0]    REG_STATUS  = 2'd1;
  localparam logic [1:0]    REG_DIV     = 2'd2;
  localparam logic [1:0]    REG_NONE    = 2'd3;
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;
  typedef enum logic [1:0] { TX_IDLE, TX_START, TX_DATA, TX_STOP } tx_state_t;

  w_state_t      w_state, w_next;
  r_state_t      r_state, r_next;
  tx_state_t     tx_state, tx_next;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] level;
  logic          full, empty, push, pop;
  logic [15:0]   div, div_eff, cnt;
  logic          bit_done;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          tx_d, tx_r;
  logic          w_accept, r_accept;
  logic [1:0]    w_tgt, bresp_r, rresp_r, rd_resp;
  logic [31:0]   rdata_r, rd_word;
  logic          unused_bits;

  assign full        = (level == DEPTH_L);
  assign empty       = (level == LW'(0));
  assign div_eff     = (div == 16'd0) ? 16'd1 : div;
  assign bit_done    = (cnt == 16'd1);
  assign w_tgt       = s.s_awaddr[3:2];
  assign push        = w_accept & (w_tgt == REG_TXDATA) & s.s_wstrb[0];
  assign uart_tx     = tx_r;
  assign uart_active = ~empty | (tx_state != TX_IDLE);
  assign unused_bits = ^{BASE_ADDR, s.s_awaddr[31:4], s.s_awaddr[1:0], s.s_araddr[31:4],
                         s.s_araddr[1:0], s.s_wdata[31:16], s.s_wstrb[3:2]};

  // Write channel FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  // Write channel FSM: next state
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (w_accept)   w_next = W_RESP; else w_next = W_IDLE;
      W_RESP:  if (s.s_bready) w_next = W_IDLE; else w_next = W_RESP;
      default: w_next = W_IDLE;
    endcase
  end

  // Write channel FSM: outputs; a TXDATA write into a full FIFO is held off, never dropped
  always_comb begin
    if (w_state == W_IDLE)
      w_accept = s.s_awvalid & s.s_wvalid & ~((w_tgt == REG_TXDATA) & full);
    else
      w_accept = 1'b0;
  end

  assign s.s_awready = w_accept;
  assign s.s_wready  = w_accept;
  assign s.s_bvalid  = (w_state == W_RESP);
  assign s.s_bresp   = bresp_r;

  // Read channel FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  // Read channel FSM: next state
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (s.s_arvalid) r_next = R_DATA; else r_next = R_IDLE;
      R_DATA:  if (s.s_rready)  r_next = R_IDLE; else r_next = R_DATA;
      default: r_next = R_IDLE;
    endcase
  end

  // Read channel FSM: outputs and register read mux (sampled at the address handshake)
  always_comb begin
    r_accept = (r_state == R_IDLE) & s.s_arvalid;
    rd_word  = 32'd0;
    rd_resp  = RESP_OKAY;
    case (s.s_araddr[3:2])
      REG_STATUS: rd_word = {16'd0, 8'(level), 5'd0, (tx_state != TX_IDLE), empty, full};
      REG_DIV:    rd_word = {16'd0, div};
      REG_NONE:   rd_resp = RESP_SLVERR;
      default:    rd_word = 32'd0;
    endcase
  end

  assign s.s_arready = (r_state == R_IDLE);
  assign s.s_rvalid  = (r_state == R_DATA);
  assign s.s_rdata   = rdata_r;
  assign s.s_rresp   = rresp_r;

  // Bus-side registers: responses, read data and the baud divisor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bresp_r <= RESP_OKAY;
      rresp_r <= RESP_OKAY;
      rdata_r <= 32'd0;
      div     <= 16'(BAUD_DIV);
    end else begin
      if (w_accept) begin
        bresp_r <= (w_tgt == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
        if (w_tgt == REG_DIV) begin
          if (s.s_wstrb[0]) div[7:0]  <= s.s_wdata[7:0];
          if (s.s_wstrb[1]) div[15:8] <= s.s_wdata[15:8];
        end
      end
      if (r_accept) begin
        rdata_r <= rd_word;
        rresp_r <= rd_resp;
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= s.s_wdata[7:0];
  end

  // FIFO pointers and level; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= AW'(0);
      rptr  <= AW'(0);
      level <= LW'(0);
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // TX FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  // TX FSM: next state
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (!empty)                          tx_next = TX_START; else tx_next = TX_IDLE;
      TX_START: if (bit_done)                        tx_next = TX_DATA;  else tx_next = TX_START;
      TX_DATA:  if (bit_done && bit_idx == 3'd7)     tx_next = TX_STOP;  else tx_next = TX_DATA;
      TX_STOP:  if (bit_done)                        tx_next = TX_IDLE;  else tx_next = TX_STOP;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // TX FSM: outputs; the line level is precomputed for the upcoming state so uart_tx is a flop
  always_comb begin
    pop = (tx_state == TX_IDLE) & ~empty;
    case (tx_next)
      TX_START: tx_d = 1'b0;
      TX_DATA:  if (tx_state == TX_DATA && bit_done) tx_d = shreg[1]; else tx_d = shreg[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // TX datapath: bit timer reloads from the live divisor at every bit boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= 8'd0;
      bit_idx <= 3'd0;
      cnt     <= 16'd1;
      tx_r    <= 1'b1;
    end else begin
      tx_r <= tx_d;
      if (pop) begin
        shreg   <= mem[rptr];
        bit_idx <= 3'd0;
        cnt     <= div_eff;
      end else if (tx_state != TX_IDLE) begin
        if (bit_done) begin
          cnt <= div_eff;
          if (tx_state == TX_DATA) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
        end else begin
          cnt <= cnt - 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi4_uart_ctrl.sv
// Self-checking bench for axi4_uart_ctrl: bus transactions feed a byte scoreboard
// that a serial-line monitor drains while checking 8N1 framing and bit timing.
`timescale 1ns/1ps
module tb_axi4_uart_ctrl;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_tx, uart_active;
  axi4_uart_ctrl_if bus();

  axi4_uart_ctrl #(
    .BASE_ADDR (32'h0000_0100),
    .FIFO_DEPTH(DEPTH),
    .BAUD_DIV  (104)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (bus.slave),
    .uart_tx    (uart_tx),
    .uart_active(uart_active)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;
  int         bit_clks = 104;
  logic       trace [64];

  int         m_d, m_bad, m_b;
  logic [7:0] m_e, m_got;
  logic       m_lvl;
  bit         m_have;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // called at posedge+1; returns at posedge+1 after the response beat
  task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        output logic [1:0] resp, output int stall);
    bus.s_awaddr  = addr;
    bus.s_wdata   = data;
    bus.s_wstrb   = strb;
    bus.s_awvalid = 1'b1;
    bus.s_wvalid  = 1'b1;
    stall = 0;
    forever begin
      @(negedge clk);
      if (bus.s_awready && bus.s_wready) break;
      stall++;
      if (stall > 4000) break;
    end
    if (stall > 4000) chk_eq("wr_timeout", bus.s_awready, 1);
    else if (addr[3:2] == 2'd0 && strb[0]) exp_q.push_back(data[7:0]);
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    @(negedge clk);
    chk_eq("bvalid_latency", bus.s_bvalid, 1);
    resp = bus.s_bresp;
    @(posedge clk); #1;
  endtask

  task automatic axi_rd(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bus.s_araddr  = addr;
    bus.s_arvalid = 1'b1;
    @(negedge clk);
    chk_eq("arready", bus.s_arready, 1);
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0;
    @(negedge clk);
    chk_eq("rvalid_latency", bus.s_rvalid, 1);
    data = bus.s_rdata;
    resp = bus.s_rresp;
    @(posedge clk); #1;
  endtask

  task automatic set_div(input logic [15:0] v);
    logic [1:0] r;
    int st;
    axi_wr(32'h0000_0108, {16'd0, v}, 4'b0011, r, st);
    chk_eq("div_bresp", r, 2'b00);
    bit_clks = (v == 16'd0) ? 1 : int'(v);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((uart_active !== 1'b0 || exp_q.size() != 0) && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20000) chk_eq(tag, uart_active, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Serial monitor: checks each frame cycle by cycle against the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && uart_tx === 1'b0) begin
        m_d    = bit_clks;
        m_bad  = 0;
        m_got  = 8'd0;
        m_have = (exp_q.size() != 0);
        m_e    = m_have ? exp_q.pop_front() : 8'd0;
        for (int c = 0; c < 10 * m_d; c++) begin
          if (c > 0) @(negedge clk);
          m_b   = c / m_d;
          m_lvl = (m_b == 0) ? 1'b0 : (m_b == 9) ? 1'b1 : m_e[m_b-1];
          if (uart_tx !== m_lvl) m_bad++;
          if (m_b >= 1 && m_b <= 8 && (c % m_d) == m_d / 2) m_got[m_b-1] = uart_tx;
        end
        chk_eq("frame_expected", m_have, 1);
        chk_eq("frame_byte", m_got, m_e);
        chk_eq("frame_shape_errs", m_bad, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, d2;
    logic [1:0]  r, r2;
    int          st, st2, n, ri, len;
    int          runs [4];

    bus.s_awvalid = 1'b0; bus.s_awaddr = 32'd0; bus.s_wvalid = 1'b0;
    bus.s_wdata   = 32'd0; bus.s_wstrb = 4'd0;  bus.s_bready = 1'b1;
    bus.s_arvalid = 1'b0; bus.s_araddr = 32'd0; bus.s_rready = 1'b1;

    // power-on reset
    repeat (3) @(negedge clk);
    chk_eq("rst_uart_tx", uart_tx, 1);
    chk_eq("rst_active", uart_active, 0);
    chk_eq("rst_bvalid", bus.s_bvalid, 0);
    chk_eq("rst_rvalid", bus.s_rvalid, 0);
    chk_eq("rst_rdata", bus.s_rdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_rd(32'h0000_0108, d, r);
    chk_eq("div_reset", d, 32'd104);
    chk_eq("div_rresp", r, 2'b00);
    axi_rd(32'h0000_0104, d, r);
    chk_eq("status_reset", d, 32'h0000_0002);

    // reset in the middle of a frame
    axi_wr(32'h0000_0100, 32'h0000_00A5, 4'b0001, r, st);
    repeat (30) @(posedge clk);
    #1;
    chk_eq("midframe_tx_low", uart_tx, 0);
    chk_eq("midframe_active", uart_active, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_eq("abort_uart_tx", uart_tx, 1);
    chk_eq("abort_active", uart_active, 0);
    chk_eq("abort_bvalid", bus.s_bvalid, 0);
    chk_eq("abort_rvalid", bus.s_rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    axi_rd(32'h0000_0104, d, r);
    chk_eq("status_after_abort", d, 32'h0000_0002);

    // single byte at 4 clocks per bit
    mon_en = 1'b1;
    set_div(16'd4);
    axi_wr(32'h0000_0100, 32'h0000_0055, 4'b0001, r, st);
    chk_eq("b1_bresp", r, 2'b00);
    chk_eq("b1_start_edge", uart_tx, 0);
    n = 0;
    forever begin
      @(negedge clk);
      if (uart_active !== 1'b1 || n > 200) break;
      n++;
    end
    chk_eq("b1_active_clocks", n, 40);
    wait_idle("b1_drain");

    // backpressure with a 4-entry FIFO
    set_div(16'd8);
    for (int i = 0; i < 5; i++) begin
      axi_wr(32'h0000_0100, 32'(32'hA0 + i), 4'b0001, r, st);
      chk_eq("bp_no_stall", st, 0);
    end
    axi_rd(32'h0000_0104, d, r);
    chk_eq("bp_status_full", d, 32'h0000_0405);
    axi_wr(32'h0000_0100, 32'h0000_00A5, 4'b0001, r, st);
    chk_eq("bp_6th_stalled", (st > 10), 1);
    wait_idle("bp_drain");
    axi_rd(32'h0000_0104, d, r);
    chk_eq("bp_status_empty", d, 32'h0000_0002);

    // pointer wrap-around: 3*DEPTH+1 bytes
    set_div(16'd2);
    for (int i = 0; i < 3 * DEPTH + 1; i++)
      axi_wr(32'h0000_0100, 32'(32'h30 + i), 4'b0001, r, st);
    wait_idle("wrap_drain");

    // DIV of zero behaves as one clock per bit
    set_div(16'd0);
    axi_wr(32'h0000_0100, 32'h0000_00C3, 4'b0001, r, st);
    wait_idle("div0_drain");

    // divisor change during the DATA state
    mon_en = 1'b0;
    set_div(16'd4);
    axi_wr(32'h0000_0100, 32'h0000_0055, 4'b0001, r, st);
    exp_q.delete();
    fork
      begin
        for (int c = 0; c < 64; c++) begin
          @(negedge clk);
          trace[c] = uart_tx;
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        axi_wr(32'h0000_0108, 32'd12, 4'b0011, r2, st2);
      end
    join
    ri = 0;
    len = 1;
    for (int c = 1; c < 64; c++) begin
      if (trace[c] == trace[c-1]) len++;
      else begin
        if (ri < 4) runs[ri] = len;
        ri++;
        len = 1;
      end
    end
    chk_eq("rt_first_level", trace[0], 0);
    chk_eq("rt_start_len", runs[0], 4);
    chk_eq("rt_bit0_len", runs[1], 4);
    chk_eq("rt_bit1_len", runs[2], 12);
    chk_eq("rt_bit2_len", runs[3], 12);
    wait_idle("rt_drain");
    set_div(16'd3);
    mon_en = 1'b1;

    // unmapped register, read-only STATUS, masked TXDATA byte
    axi_wr(32'h0000_010C, 32'hFFFF_FFFF, 4'b1111, r, st);
    chk_eq("unmapped_bresp", r, 2'b10);
    axi_rd(32'h0000_010C, d, r);
    chk_eq("unmapped_rdata", d, 32'd0);
    chk_eq("unmapped_rresp", r, 2'b10);
    axi_wr(32'h0000_0104, 32'hFFFF_FFFF, 4'b1111, r, st);
    chk_eq("status_wr_bresp", r, 2'b00);
    axi_wr(32'h0000_0100, 32'h0000_0077, 4'b0010, r, st);
    chk_eq("masked_tx_bresp", r, 2'b00);
    axi_rd(32'h0000_0104, d, r);
    chk_eq("masked_not_pushed", d, 32'h0000_0002);
    axi_rd(32'h0000_0100, d, r);
    chk_eq("txdata_reads_zero", d, 32'd0);
    axi_rd(32'h0000_0108, d, r);
    chk_eq("div_readback", d, 32'd3);

    // concurrent STATUS read and TXDATA write
    fork
      axi_wr(32'h0000_0100, 32'h0000_003C, 4'b0001, r, st);
      axi_rd(32'h0000_0104, d2, r2);
    join
    chk_eq("conc_bresp", r, 2'b00);
    chk_eq("conc_rresp", r2, 2'b00);
    chk_eq("conc_status_prepush", d2, 32'h0000_0002);
    wait_idle("conc_drain");

    chk_eq("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi4_uart_ctrl.md
# axi4_uart_ctrl

Parametrised AXI4 slave UART transmitter that replaces the single-word UART bridge on the CPU data port. It buffers bytes in a configurable TX FIFO, applies real AXI backpressure and write responses, exposes a readable status register and a run-time baud divisor, and serialises 8N1 frames on `uart_tx`. It sits on `master_d` of the core, decoded at `BASE_ADDR`, and runs on the internal 12 MHz oscillator clock.

## Interface
- `BASE_ADDR`, default 32'h0000_0100: register window base; window is 16 bytes.
- `FIFO_DEPTH`, default 16: TX FIFO entries; a power of two, 2..128.
- `BAUD_DIV`, default 104: reset value of the DIV register, in clocks per bit (12 MHz / 115200).
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_awvalid` in 1, `s_awready` out 1, `s_awaddr` in 32: write address channel.
- `s_wvalid` in 1, `s_wready` out 1, `s_wdata` in 32, `s_wstrb` in 4: write data channel.
- `s_bvalid` out 1, `s_bready` in 1, `s_bresp` out 2: write response channel.
- `s_arvalid` in 1, `s_arready` out 1, `s_araddr` in 32: read address channel.
- `s_rvalid` out 1, `s_rready` in 1, `s_rdata` out 32, `s_rresp` out 2: read data channel.
- `uart_tx` out 1: serial line; idles high.
- `uart_active` out 1: high while the FIFO is non-empty or a frame is in flight.

## Operation
- Register decode uses `addr[3:2]`:
  - 0x0 TXDATA: a write pushes `wdata[7:0]` when `wstrb[0]` is set. A write with `wstrb[0]` clear is not pushed and still returns OKAY. Reads return 0.
  - 0x4 STATUS (read only): bit0 = full, bit1 = empty, bit2 = busy (TX FSM not IDLE), bits[15:8] = FIFO level. Writes are ignored and return OKAY.
  - 0x8 DIV (rw, 16 bits): bytes are written per `wstrb[1:0]`. A value of 0 is treated as 1.
  - 0xC is unmapped: writes are ignored, reads return 0, and the response is SLVERR (2'b10).
- All other responses are OKAY (2'b00). `addr[31:4]` is not checked; the interconnect decodes it.
- Write FSM, states W_IDLE and W_RESP:
  - In W_IDLE, `s_awready` = `s_wready` = `s_awvalid & s_wvalid & ~(target==TXDATA & full)`. Both handshakes complete in the same cycle.
  - A TXDATA write when the FIFO is full stalls with ready low until space frees; it is never dropped.
  - On the handshake the register or FIFO is updated and the FSM enters W_RESP with `s_bvalid` = 1. It holds there until `s_bready`, then returns to W_IDLE.
- Read FSM, states R_IDLE and R_DATA:
  - `s_arready` = 1 in R_IDLE.
  - On `s_arvalid`, `s_rdata`/`s_rresp` are registered and `s_rvalid` = 1. The read is held stable until `s_rready`, then returns to R_IDLE.
  - The write and read FSMs are independent and may complete in the same cycle.
- TX FSM, states IDLE, START, DATA, STOP:
  - In IDLE with the FIFO non-empty, the head is popped into an 8-bit shift register and the FSM enters START.
  - START drives 0 for one bit time, DATA drives 8 bits LSB first, STOP drives 1 for one bit time, then the FSM returns to IDLE.
  - A bit counter reloads from max(DIV,1) at each bit boundary, so a DIV write mid-frame takes effect at the next bit.
- FIFO: circular buffer with `$clog2(FIFO_DEPTH)`-bit pointers that wrap and a `$clog2(FIFO_DEPTH)+1`-bit level.
  - A simultaneous push and pop leaves the level unchanged.
  - A pop when empty cannot occur, because IDLE checks empty first.

## Timing
- Reset (asynchronous, any state):
  - `uart_tx` = 1, `uart_active` = 0.
  - `s_bvalid` = `s_rvalid` = 0, `s_rdata` = 0, `s_bresp` = `s_rresp` = 0.
  - DIV = `BAUD_DIV`, FIFO empty, all FSMs idle.
  - A frame in flight is aborted and the line goes high immediately.
- Write latency: handshake in cycle N, `s_bvalid` high in N+1. Back-to-back throughput is one write per 2 cycles with `s_bready` tied high.
- Read latency: `s_arvalid` & `s_arready` in N, `s_rvalid` high in N+1. STATUS reflects state as of cycle N.
- Push in N: the FIFO level increments in N+1. If TX was IDLE, the pop occurs in N+1 and `uart_tx` falls in N+2.
- One frame is 10×D clocks (D = effective DIV), followed by one IDLE cycle (line high) before the next start bit.
- `uart_active` rises the cycle after the first push and falls the cycle after STOP ends with the FIFO empty.

## Test plan
- Reset: hold `rst_n` low mid-frame → `uart_tx` = 1 and all valids 0 in the same cycle. After release, reading DIV returns 104 and STATUS returns 0x0000_0002.
- Single byte: write 0x55 to 0x100 with DIV = 4 → `s_bvalid` in the next cycle, `s_bresp` = 0. `uart_tx` shows a 0 start bit, bits 1,0,1,0,1,0,1,0, and a stop bit, each exactly 4 clocks; `uart_active` drops after 40 clocks.
- Backpressure: DIV = 8, `FIFO_DEPTH` = 4, push 6 bytes back-to-back → STATUS reads full = 1 and level = 4. The 6th write stalls with `s_wready` low until a pop, all 6 bytes appear in order, and none are lost.
- Wrap-around: push and drain 3×`FIFO_DEPTH` + 1 bytes with incrementing values → the serial output sequence matches exactly.
- Run-time divisor: write DIV = 0 → bit time is 1 clock. Write DIV = 12 during the DATA state → the current bit keeps its old length and the next bit lasts 12 clocks.
- Error and concurrency: write and read 0x10C → SLVERR, read data 0. Issue a STATUS read in the same cycle as a TXDATA write → both complete, and the read returns the pre-push level.
